pipe_ex_mem: RTL



---
 rtl/pipe_ex_mem.sv | 88 ++++++++
 1 files changed

// File: rtl/pipe_ex_mem.sv
// Execute stage of the LEGv8 pipeline: ALU, branch resolution and the EX/MEM register.
// Fetch redirect (ex_pcsrc/ex_branch_target) is combinational off the current ex_* bundle.
module pipe_ex_mem (
  input  logic        clk,
  input  logic        resetl,
  input  logic        ex_valid,
  input  logic [63:0] ex_busA,
  input  logic [63:0] ex_busB,
  input  logic [63:0] ex_nextseqpc,
  input  logic [63:0] ex_immediate,
  input  logic [4:0]  ex_rd,
  input  logic        ex_alusrc,
  input  logic        ex_mem2reg,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_branch,
  input  logic        ex_uncond_branch,
  input  logic [3:0]  ex_aluctrl,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        ex_pcsrc,
  output logic [63:0] ex_branch_target,
  output logic        mem_valid,
  output logic [63:0] mem_alu_result,
  output logic [63:0] mem_writedata,
  output logic [63:0] mem_nextseqpc,
  output logic [4:0]  mem_rd,
  output logic        mem_zero,
  output logic        mem_mem2reg,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic        mem_memwrite
);

  logic [63:0] operand_b;
  logic [63:0] alu_result;
  logic        zero;

  assign operand_b = ex_alusrc ? ex_immediate : ex_busB;

  always_comb begin
    alu_result = 64'd0;
    unique case (ex_aluctrl)
      4'b0000: alu_result = ex_busA & operand_b;
      4'b0001: alu_result = ex_busA | operand_b;
      4'b0010: alu_result = ex_busA + operand_b;
      4'b0110: alu_result = ex_busA - operand_b;
      4'b0111: alu_result = operand_b;
      4'b1100: alu_result = ~(ex_busA | operand_b);
      default: alu_result = 64'd0;
    endcase
  end

  assign zero = (alu_result == 64'd0);

  // Branch offsets are word counts relative to the branch's own PC.
  assign ex_branch_target = (ex_nextseqpc - 64'd4) + (ex_immediate << 2);
  assign ex_pcsrc         = ex_valid & (ex_uncond_branch | (ex_branch & zero));

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl || flush) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= 64'd0;
      mem_writedata  <= 64'd0;
      mem_nextseqpc  <= 64'd0;
      mem_rd         <= 5'd0;
      mem_zero       <= 1'b0;
      mem_mem2reg    <= 1'b0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
    end else if (!mem_stall) begin
      mem_valid      <= ex_valid;
      mem_alu_result <= alu_result;
      mem_writedata  <= ex_busB;
      mem_nextseqpc  <= ex_nextseqpc;
      mem_rd         <= ex_rd;
      mem_zero       <= zero;
      mem_mem2reg    <= ex_mem2reg;
      // A bubble must never produce architectural side effects downstream.
      mem_regwrite   <= ex_regwrite & ex_valid;
      mem_memread    <= ex_memread & ex_valid;
      mem_memwrite   <= ex_memwrite & ex_valid;
    end
  end

endmodule
